// File: rtl/alu_seq_nb.sv
// N-bit ALU with valid/ready handshake and registered result/flags.
// Define ALU_SEQ_MUL_EN to build op 111 as an iterative shift-add multiplier.
module alu_seq_nb #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] z,
   output logic             flag_c,
   output logic             flag_z,
   output logic             flag_n,
   output logic             flag_v
);
   localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010, OP_OR  = 3'b011,
                          OP_XOR = 3'b100, OP_PA  = 3'b101, OP_PB  = 3'b110, OP_MUL = 3'b111;
   localparam int MSB = WIDTH - 1;

`ifdef ALU_SEQ_MUL_EN
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
`else
   typedef enum logic [1:0] {IDLE, DONE} state_t;
`endif

   state_t           state, state_nxt;
   logic             accept;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] b_eff, res;
   logic             res_c, res_v;
   logic             load, ld_c, ld_v;
   logic [WIDTH-1:0] ld_z;

`ifdef ALU_SEQ_MUL_EN
   logic [2*WIDTH-1:0] acc, mcand, acc_nxt;
   logic [WIDTH-1:0]   mplier;
   logic [CNT_W-1:0]   cnt;
   logic               start_mul, last_iter;

   always_comb begin
      start_mul = accept & (op == OP_MUL);
      last_iter = (cnt == CNT_W'(WIDTH - 1));
      acc_nxt   = acc + (mplier[0] ? mcand : '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         cnt    <= '0;
      end else if (start_mul) begin
         acc    <= '0;
         mcand  <= {{WIDTH{1'b0}}, a};
         mplier <= b;
         cnt    <= '0;
      end else if (state == BUSY) begin
         acc    <= acc_nxt;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt + CNT_W'(1);
      end
   end
`endif

   // SUB is a + ~b + 1, so the carry-in slot carries the +1.
   always_comb begin
      b_eff = (op == OP_SUB) ? ~b : b;
      sum   = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, (op == OP_SUB) | cin};
      res   = '0;
      res_c = 1'b0;
      res_v = 1'b0;
      case (op)
         OP_ADD, OP_SUB: begin
            res   = sum[WIDTH-1:0];
            res_c = sum[WIDTH];
            res_v = (a[MSB] == b_eff[MSB]) & (sum[MSB] != a[MSB]);
         end
         OP_AND:  res = a & b;
         OP_OR:   res = a | b;
         OP_XOR:  res = a ^ b;
         OP_PA:   res = a;
         OP_PB:   res = b;
         OP_MUL:  res = '0;
         default: res = '0;
      endcase
   end

   // Result source: ALU on a single-cycle accept, accumulator on the final multiply step.
   always_comb begin
      load = accept;
      ld_z = res;
      ld_c = res_c;
      ld_v = res_v;
`ifdef ALU_SEQ_MUL_EN
      if (state == BUSY) begin
         load = last_iter;
         ld_z = acc_nxt[WIDTH-1:0];
         ld_c = |acc_nxt[2*WIDTH-1:WIDTH];
         ld_v = 1'b0;
      end else if (start_mul) begin
         load = 1'b0;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         z      <= '0;
         flag_c <= 1'b0;
         flag_z <= 1'b0;
         flag_n <= 1'b0;
         flag_v <= 1'b0;
      end else if (load) begin
         z      <= ld_z;
         flag_c <= ld_c;
         flag_z <= (ld_z == '0);
         flag_n <= ld_z[MSB];
         flag_v <= ld_v;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // accept can only occur in IDLE or DONE since in_ready is low while BUSY.
   always_comb begin
      state_nxt = state;
      if (accept) begin
`ifdef ALU_SEQ_MUL_EN
         state_nxt = start_mul ? BUSY : DONE;
`else
         state_nxt = DONE;
`endif
      end else if (state == DONE && out_ready) begin
         state_nxt = IDLE;
`ifdef ALU_SEQ_MUL_EN
      end else if (state == BUSY && last_iter) begin
         state_nxt = DONE;
`endif
      end
   end

   always_comb begin
      in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
      out_valid = (state == DONE);
      accept    = in_valid & in_ready;
   end
endmodule
